stopwatch_sequencer: RTL and testbench
======================================

# stopwatch_sequencer

Control block for a chain of cascaded BCD digit counters. It runs a start/stop/lap/clear state machine and generates the chain's count-enable tick from a programmable prescaler. It also issues a synchronous clear pulse to the chain and time-multiplexes the digit values onto a single scanned display digit, with optional lap freeze. It sits between debounced button pulses and the counter chain / 7-segment driver.

## Interface
- TICK_DIV, 100000: clock cycles per count tick; legal range ≥2.
- NUM_DIGITS, 4: digits in the chain and on the display; legal range 1..8.
- SCAN_DIV, 1000: clock cycles each display digit is held; legal range ≥1.

- i_CLK  in  1  sole clock; all logic on rising edge.
- i_RST  in  1  asynchronous, active-high reset.
- i_START_STOP  in  1  one-cycle command pulse; toggles run/stop.
- i_LAP  in  1  one-cycle command pulse; toggles lap freeze.
- i_CLEAR  in  1  one-cycle command pulse; zeroes the chain when stopped.
- i_DIGITS  in  4*NUM_DIGITS  live chain value; digit n is bits [4n+3:4n], digit 0 least significant.
- o_CNT_EN  out  1  one-cycle count-enable tick to digit 0 of the chain.
- o_CNT_RST  out  1  one-cycle clear pulse to the chain.
- o_SCAN_SEL  out  NUM_DIGITS  one-hot, active-high digit select.
- o_SCAN_DIGIT  out  4  BCD value for the selected digit.
- o_RUNNING  out  1  high in RUN or LAP_HOLD.
- o_LAP_HELD  out  1  high in LAP_HOLD.

## Operation
- States: IDLE, RUN, PAUSE, LAP_HOLD. Reset state is IDLE.
- Command priority when pulses coincide: START_STOP > CLEAR > LAP. Only the highest-priority pulse that is legal in the current state acts. All others are dropped.
- IDLE transitions:
  - START_STOP → RUN.
  - CLEAR → stay in IDLE, zero the prescaler, pulse o_CNT_RST.
  - LAP is ignored.
- RUN transitions:
  - START_STOP → PAUSE.
  - LAP → LAP_HOLD, capturing i_DIGITS into the lap register.
  - CLEAR is ignored.
- LAP_HOLD transitions:
  - LAP → RUN, releasing the freeze.
  - START_STOP → PAUSE, releasing the freeze.
  - CLEAR is ignored.
  - Counting continues.
- PAUSE transitions:
  - START_STOP → RUN.
  - CLEAR → IDLE, zero the prescaler, pulse o_CNT_RST.
  - LAP is ignored.
- Prescaler:
  - Width $clog2(TICK_DIV); counts 0..TICK_DIV-1.
  - Increments only on edges where the pre-edge state is RUN or LAP_HOLD. Holds in PAUSE, so the partial period is preserved across a pause.
  - Wraps to 0 on the same edge that sets o_CNT_EN.
- Lap register:
  - Samples the pre-edge i_DIGITS on the accepting edge. A simultaneous chain update is not included.
- Display scan:
  - Runs in every state.
  - Scan divider counts 0..SCAN_DIV-1. The digit index advances on the divider's terminal count and wraps from NUM_DIGITS-1 to 0.
  - Source is the lap register in LAP_HOLD, otherwise i_DIGITS.
- Reset values: state IDLE, prescaler 0, scan divider 0, index 0, lap register 0, and every output 0 (including o_SCAN_SEL).
- Reset mid-operation: all of the above take effect immediately, with no clock needed. No o_CNT_RST pulse is generated.

## Timing
- Command pulses are sampled on the rising edge. The new state is visible after that edge, and o_RUNNING / o_LAP_HELD follow in the same cycle.
- o_CNT_EN:
  - Registered. Set on the edge where the prescaler equals TICK_DIV-1 and the pre-edge state is RUN or LAP_HOLD; clears on the next edge.
  - Starting from prescaler 0 with RUN entered at edge k, ticks are high for one cycle after edges k+TICK_DIV, k+2·TICK_DIV, and so on. Period is exactly TICK_DIV cycles.
  - A tick due on the same edge that accepts a stop is still issued.
- o_CNT_RST: registered; high for exactly the one cycle following the edge that accepted CLEAR.
- o_SCAN_SEL and o_SCAN_DIGIT:
  - Registered from the current index and source, so they lag the index by one cycle.
  - After reset release, the first edge gives SEL=bit 0.
- Freeze and release: entering or leaving LAP_HOLD changes o_SCAN_DIGIT one cycle after the transition edge.

## Test plan
Parameters: TICK_DIV=4, NUM_DIGITS=4, SCAN_DIV=2.

- Run from reset: after reset, START_STOP at edge k → o_RUNNING=1 after k; o_CNT_EN is one-cycle high after edges k+4, k+8 and k+12, and low otherwise.
- Pause preserves the partial period: START_STOP (stop) when the prescaler is 2 → no o_CNT_EN over 10 paused cycles. START_STOP (resume) at edge r → o_CNT_EN high after edge r+2.
- Lap freeze: i_DIGITS=16'h0123 on the LAP edge, then 16'h0456 → scan shows 3,2,1,0 with o_LAP_HELD=1 and o_CNT_EN still ticking. A second LAP → scan shows 6,5,4,0.
- Clear legality: CLEAR in PAUSE → o_CNT_RST high for exactly one cycle, state IDLE, o_RUNNING=0. CLEAR in RUN or LAP_HOLD → o_CNT_RST stays 0 and the state is unchanged.
- Priority: START_STOP and CLEAR together in PAUSE → RUN, o_CNT_RST=0. LAP and CLEAR together in RUN → LAP_HOLD, o_CNT_RST=0.
- Asynchronous reset: assert i_RST mid-cycle in LAP_HOLD with the prescaler at 3 → all outputs 0 immediately, before any edge. After release, the state is IDLE and a START_STOP gives its first tick 4 cycles later.

Source files
------------

// File: rtl/stopwatch_sequencer_if.sv
// Command, chain and display signals between the button/counter side and the
// stopwatch sequencer. The sequencer uses the slave modport.
interface stopwatch_sequencer_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    i_START_STOP;
  logic                    i_LAP;
  logic                    i_CLEAR;
  logic [4*NUM_DIGITS-1:0] i_DIGITS;
  logic                    o_CNT_EN;
  logic                    o_CNT_RST;
  logic [NUM_DIGITS-1:0]   o_SCAN_SEL;
  logic [3:0]              o_SCAN_DIGIT;
  logic                    o_RUNNING;
  logic                    o_LAP_HELD;

  modport master (
    output i_START_STOP, i_LAP, i_CLEAR, i_DIGITS,
    input  o_CNT_EN, o_CNT_RST, o_SCAN_SEL, o_SCAN_DIGIT, o_RUNNING, o_LAP_HELD
  );

  modport slave (
    input  i_START_STOP, i_LAP, i_CLEAR, i_DIGITS,
    output o_CNT_EN, o_CNT_RST, o_SCAN_SEL, o_SCAN_DIGIT, o_RUNNING, o_LAP_HELD
  );
endinterface

// File: rtl/stopwatch_sequencer.sv
// Start/stop/lap/clear controller for a cascaded BCD counter chain, with a
// count-enable prescaler and a scanned single-digit display output.
module stopwatch_sequencer #(
  parameter int TICK_DIV   = 100000,
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  stopwatch_sequencer_if.slave  bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP_HOLD} state_t;

  state_t                  state;
  logic [PW-1:0]           presc;
  logic [SW-1:0]           scan_div;
  logic [IW-1:0]           scan_idx;
  logic [DW-1:0]           lap_q;
  logic                    cnt_en_q;
  logic                    cnt_rst_q;
  logic                    running_q;
  logic                    lap_held_q;
  logic [NUM_DIGITS-1:0]   scan_sel_q;
  logic [3:0]              scan_digit_q;
  logic                    counting;
  logic                    clear_ok;
  logic [DW-1:0]           scan_src;

  // START_STOP outranks CLEAR, and CLEAR only acts while the chain is stopped.
  assign counting = (state == RUN) || (state == LAP_HOLD);
  assign clear_ok = bus.i_CLEAR && !bus.i_START_STOP && ((state == IDLE) || (state == PAUSE));
  assign scan_src = (state == LAP_HOLD) ? lap_q : bus.i_DIGITS;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state      <= IDLE;
      running_q  <= 1'b0;
      lap_held_q <= 1'b0;
      cnt_rst_q  <= 1'b0;
      lap_q      <= '0;
    end else begin
      cnt_rst_q <= clear_ok;
      case (state)
        IDLE: begin
          if (bus.i_START_STOP) begin
            state     <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.i_START_STOP) begin
            state     <= PAUSE;
            running_q <= 1'b0;
          end else if (bus.i_LAP) begin
            state      <= LAP_HOLD;
            lap_held_q <= 1'b1;
            lap_q      <= bus.i_DIGITS;
          end
        end
        LAP_HOLD: begin
          if (bus.i_START_STOP) begin
            state      <= PAUSE;
            running_q  <= 1'b0;
            lap_held_q <= 1'b0;
          end else if (bus.i_LAP) begin
            state      <= RUN;
            lap_held_q <= 1'b0;
          end
        end
        PAUSE: begin
          if (bus.i_START_STOP) begin
            state     <= RUN;
            running_q <= 1'b1;
          end else if (clear_ok) begin
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          running_q  <= 1'b0;
          lap_held_q <= 1'b0;
        end
      endcase
    end
  end

  // Prescaler holds while paused so a resumed run keeps its partial period.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      presc    <= '0;
      cnt_en_q <= 1'b0;
    end else begin
      cnt_en_q <= 1'b0;
      if (clear_ok) begin
        presc <= '0;
      end else if (counting) begin
        if (presc == PW'(TICK_DIV - 1)) begin
          presc    <= '0;
          cnt_en_q <= 1'b1;
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      scan_div     <= '0;
      scan_idx     <= '0;
      scan_sel_q   <= '0;
      scan_digit_q <= '0;
    end else begin
      if (scan_div == SW'(SCAN_DIV - 1)) begin
        scan_div <= '0;
        scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + IW'(1);
      end else begin
        scan_div <= scan_div + SW'(1);
      end
      scan_sel_q   <= NUM_DIGITS'(1) << scan_idx;
      scan_digit_q <= scan_src[{scan_idx, 2'b00} +: 4];
    end
  end

  assign bus.o_CNT_EN     = cnt_en_q;
  assign bus.o_CNT_RST    = cnt_rst_q;
  assign bus.o_SCAN_SEL   = scan_sel_q;
  assign bus.o_SCAN_DIGIT = scan_digit_q;
  assign bus.o_RUNNING    = running_q;
  assign bus.o_LAP_HELD   = lap_held_q;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Scenario bench for stopwatch_sequencer with TICK_DIV=4, NUM_DIGITS=4, SCAN_DIV=2;
// expected ticks and display sources are queued as stimulus is driven.
module tb_stopwatch_sequencer;

  localparam int TICK_DIV   = 4;
  localparam int NUM_DIGITS = 4;
  localparam int SCAN_DIV   = 2;

  logic i_CLK = 1'b0;
  logic i_RST = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   edges = 0;
  int   tick_q[$];
  logic [15:0] scan_q[$];

  stopwatch_sequencer_if #(.NUM_DIGITS(NUM_DIGITS)) swif ();

  stopwatch_sequencer #(
    .TICK_DIV  (TICK_DIV),
    .NUM_DIGITS(NUM_DIGITS),
    .SCAN_DIV  (SCAN_DIV)
  ) dut (
    .i_CLK(i_CLK),
    .i_RST(i_RST),
    .bus  (swif)
  );

  always #5 i_CLK = ~i_CLK;

  // Edges since reset release; the scan index is a pure function of this count.
  always @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) edges <= 0;
    else       edges <= edges + 1;
  end

  task automatic apply_stimulus(input logic ss, input logic lp, input logic cl);
    swif.i_START_STOP = ss;
    swif.i_LAP        = lp;
    swif.i_CLEAR      = cl;
    @(posedge i_CLK);
    #1;
    swif.i_START_STOP = 1'b0;
    swif.i_LAP        = 1'b0;
    swif.i_CLEAR      = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] outs;
    swif.i_START_STOP = 1'b0;
    swif.i_LAP        = 1'b0;
    swif.i_CLEAR      = 1'b0;
    swif.i_DIGITS     = 16'h0000;
    i_RST = 1'b1;
    #1;
    outs = {swif.o_CNT_EN, swif.o_CNT_RST, swif.o_SCAN_SEL, swif.o_SCAN_DIGIT, swif.o_RUNNING, swif.o_LAP_HELD};
    checks++; if (outs !== 12'h000) begin failures++; $display("[TB] FAIL reset_outputs: got %h expected 000", outs); end
    repeat (2) @(posedge i_CLK);
    #1;
    outs = {swif.o_CNT_EN, swif.o_CNT_RST, swif.o_SCAN_SEL, swif.o_SCAN_DIGIT, swif.o_RUNNING, swif.o_LAP_HELD};
    checks++; if (outs !== 12'h000) begin failures++; $display("[TB] FAIL reset_held: got %h expected 000", outs); end
    @(negedge i_CLK);
    i_RST = 1'b0;
  endtask

  task automatic test_run_from_reset();
    logic exp;
    apply_stimulus(1'b1, 1'b0, 1'b0);
    checks++; if (swif.o_RUNNING !== 1'b1) begin failures++; $display("[TB] FAIL run_running: got %b expected 1", swif.o_RUNNING); end
    checks++; if (swif.o_SCAN_SEL !== 4'b0001) begin failures++; $display("[TB] FAIL first_sel: got %b expected 0001", swif.o_SCAN_SEL); end
    tick_q = '{4, 8, 12};
    for (int n = 1; n <= 13; n++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0);
      exp = (tick_q.size() != 0 && tick_q[0] == n);
      if (exp) void'(tick_q.pop_front());
      checks++; if (swif.o_CNT_EN !== exp) begin failures++; $display("[TB] FAIL run_tick[%0d]: got %b expected %b", n, swif.o_CNT_EN, exp); end
    end
  endtask

  task automatic test_pause();
    logic exp;
    int   seen;
    // Stop on the edge that moves the prescaler from 1 to 2.
    apply_stimulus(1'b1, 1'b0, 1'b0);
    checks++; if (swif.o_RUNNING !== 1'b0) begin failures++; $display("[TB] FAIL pause_running: got %b expected 0", swif.o_RUNNING); end
    seen = 0;
    repeat (10) begin
      apply_stimulus(1'b0, 1'b0, 1'b0);
      if (swif.o_CNT_EN === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("[TB] FAIL pause_ticks: got %0d expected 0", seen); end
    apply_stimulus(1'b1, 1'b0, 1'b0);
    checks++; if (swif.o_RUNNING !== 1'b1) begin failures++; $display("[TB] FAIL resume_running: got %b expected 1", swif.o_RUNNING); end
    tick_q = '{2, 6};
    for (int n = 1; n <= 6; n++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0);
      exp = (tick_q.size() != 0 && tick_q[0] == n);
      if (exp) void'(tick_q.pop_front());
      checks++; if (swif.o_CNT_EN !== exp) begin failures++; $display("[TB] FAIL resume_tick[%0d]: got %b expected %b", n, swif.o_CNT_EN, exp); end
    end
  endtask

  task automatic test_lap_freeze();
    logic [15:0] src;
    logic [3:0]  exp_sel;
    logic [3:0]  exp_dig;
    logic        exp_held;
    int          idx;
    int          ticks;
    ticks = 0;
    for (int n = 0; n < 18; n++) begin
      swif.i_DIGITS = (n == 0) ? 16'h0123 : 16'h0456;
      scan_q.push_back((n <= 9) ? 16'h0123 : 16'h0456);
      apply_stimulus(1'b0, (n == 0 || n == 9), 1'b0);
      src      = scan_q.pop_front();
      idx      = ((edges - 1) / SCAN_DIV) % NUM_DIGITS;
      exp_sel  = 4'b0001 << idx;
      exp_dig  = 4'(src >> (4 * idx));
      exp_held = (n <= 8);
      checks++; if (swif.o_SCAN_SEL !== exp_sel) begin failures++; $display("[TB] FAIL lap_sel[%0d]: got %b expected %b", n, swif.o_SCAN_SEL, exp_sel); end
      checks++; if (swif.o_SCAN_DIGIT !== exp_dig) begin failures++; $display("[TB] FAIL lap_digit[%0d]: got %0h expected %0h", n, swif.o_SCAN_DIGIT, exp_dig); end
      checks++; if (swif.o_LAP_HELD !== exp_held) begin failures++; $display("[TB] FAIL lap_held[%0d]: got %b expected %b", n, swif.o_LAP_HELD, exp_held); end
      if (n >= 1 && n <= 8 && swif.o_CNT_EN === 1'b1) ticks++;
    end
    checks++; if (ticks !== 2) begin failures++; $display("[TB] FAIL lap_ticks: got %0d expected 2", ticks); end
  endtask

  task automatic test_clear();
    logic exp;
    apply_stimulus(1'b0, 1'b0, 1'b1);
    checks++; if (swif.o_CNT_RST !== 1'b0) begin failures++; $display("[TB] FAIL clear_in_run: got %b expected 0", swif.o_CNT_RST); end
    checks++; if (swif.o_RUNNING !== 1'b1) begin failures++; $display("[TB] FAIL clear_run_state: got %b expected 1", swif.o_RUNNING); end
    apply_stimulus(1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    checks++; if (swif.o_CNT_RST !== 1'b0) begin failures++; $display("[TB] FAIL clear_in_lap: got %b expected 0", swif.o_CNT_RST); end
    checks++; if (swif.o_LAP_HELD !== 1'b1) begin failures++; $display("[TB] FAIL clear_lap_state: got %b expected 1", swif.o_LAP_HELD); end
    apply_stimulus(1'b1, 1'b0, 1'b0);
    checks++; if ({swif.o_RUNNING, swif.o_LAP_HELD} !== 2'b00) begin failures++; $display("[TB] FAIL stop_from_lap: got %b expected 00", {swif.o_RUNNING, swif.o_LAP_HELD}); end
    apply_stimulus(1'b0, 1'b0, 1'b1);
    checks++; if (swif.o_CNT_RST !== 1'b1) begin failures++; $display("[TB] FAIL clear_in_pause: got %b expected 1", swif.o_CNT_RST); end
    checks++; if (swif.o_RUNNING !== 1'b0) begin failures++; $display("[TB] FAIL clear_pause_state: got %b expected 0", swif.o_RUNNING); end
    apply_stimulus(1'b0, 1'b1, 1'b0);
    checks++; if (swif.o_CNT_RST !== 1'b0) begin failures++; $display("[TB] FAIL clear_pulse_width: got %b expected 0", swif.o_CNT_RST); end
    checks++; if (swif.o_LAP_HELD !== 1'b0) begin failures++; $display("[TB] FAIL lap_in_idle: got %b expected 0", swif.o_LAP_HELD); end
    // The paused prescaler was nonzero, so a first tick at 4 shows it was zeroed.
    apply_stimulus(1'b1, 1'b0, 1'b0);
    tick_q = '{4};
    for (int n = 1; n <= 5; n++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0);
      exp = (tick_q.size() != 0 && tick_q[0] == n);
      if (exp) void'(tick_q.pop_front());
      checks++; if (swif.o_CNT_EN !== exp) begin failures++; $display("[TB] FAIL idle_start_tick[%0d]: got %b expected %b", n, swif.o_CNT_EN, exp); end
    end
  endtask

  task automatic test_priority();
    apply_stimulus(1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1);
    checks++; if (swif.o_RUNNING !== 1'b1) begin failures++; $display("[TB] FAIL prio_ss_clear_state: got %b expected 1", swif.o_RUNNING); end
    checks++; if (swif.o_CNT_RST !== 1'b0) begin failures++; $display("[TB] FAIL prio_ss_clear_rst: got %b expected 0", swif.o_CNT_RST); end
    apply_stimulus(1'b0, 1'b1, 1'b1);
    checks++; if (swif.o_LAP_HELD !== 1'b1) begin failures++; $display("[TB] FAIL prio_lap_clear_state: got %b expected 1", swif.o_LAP_HELD); end
    checks++; if (swif.o_CNT_RST !== 1'b0) begin failures++; $display("[TB] FAIL prio_lap_clear_rst: got %b expected 0", swif.o_CNT_RST); end
  endtask

  task automatic test_async_reset();
    logic [11:0] outs;
    logic        exp;
    int          waited;
    waited = 0;
    while (swif.o_CNT_EN !== 1'b1 && waited < 8) begin
      apply_stimulus(1'b0, 1'b0, 1'b0);
      waited++;
    end
    checks++; if (swif.o_CNT_EN !== 1'b1) begin failures++; $display("[TB] FAIL areset_tick_wait: got %b expected 1", swif.o_CNT_EN); end
    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0);
    checks++; if (swif.o_LAP_HELD !== 1'b1) begin failures++; $display("[TB] FAIL areset_pre_lap: got %b expected 1", swif.o_LAP_HELD); end
    #3;
    i_RST = 1'b1;
    #1;
    outs = {swif.o_CNT_EN, swif.o_CNT_RST, swif.o_SCAN_SEL, swif.o_SCAN_DIGIT, swif.o_RUNNING, swif.o_LAP_HELD};
    checks++; if (outs !== 12'h000) begin failures++; $display("[TB] FAIL areset_outputs: got %h expected 000", outs); end
    #2;
    i_RST = 1'b0;
    apply_stimulus(1'b1, 1'b0, 1'b0);
    checks++; if (swif.o_RUNNING !== 1'b1) begin failures++; $display("[TB] FAIL areset_restart: got %b expected 1", swif.o_RUNNING); end
    checks++; if (swif.o_SCAN_SEL !== 4'b0001) begin failures++; $display("[TB] FAIL areset_first_sel: got %b expected 0001", swif.o_SCAN_SEL); end
    tick_q = '{4};
    for (int n = 1; n <= 5; n++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0);
      exp = (tick_q.size() != 0 && tick_q[0] == n);
      if (exp) void'(tick_q.pop_front());
      checks++; if (swif.o_CNT_EN !== exp) begin failures++; $display("[TB] FAIL areset_tick[%0d]: got %b expected %b", n, swif.o_CNT_EN, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_run_from_reset();
    test_pause();
    test_lap_freeze();
    test_clear();
    test_priority();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
